// File: rtl/spi_slave_responder_pkg.sv
// Shared SPI definitions: mode decode, synchroniser depth and responder state encoding.
package spi_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic logic cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_slave_responder_if.sv
// Host-side word handshake plus SPI pins of the responder, bundled for the top-level port.
interface spi_slave_responder_if #(
  parameter int NO_OF_BYTES = 1
);
  localparam int W = 8 * NO_OF_BYTES;

  logic [W-1:0] i_TX_Byte;
  logic         i_TX_DV;
  logic         o_TX_Ready;
  logic         o_RX_DV;
  logic [W-1:0] o_RX_Byte;
  logic         o_RX_Abort;
  logic         i_SPI_Clk;
  logic         i_SPI_CS_n;
  logic         i_SPI_MOSI;
  logic         o_SPI_MISO;
  logic         o_SPI_MISO_En;

  modport slave (
    input  i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
    output o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Abort, o_SPI_MISO, o_SPI_MISO_En
  );

  modport master (
    output i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
    input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Abort, o_SPI_MISO, o_SPI_MISO_En
  );

endinterface

// File: rtl/spi_slave_responder_edge_sync.sv
// Synchronises one asynchronous pin into i_Clk and emits single-cycle lead/trail edge pulses.
module spi_edge_sync
  import spi_pkg::*;
#(
  parameter logic RST_LVL   = 1'b0,
  parameter logic LEAD_FALL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic pin_i,
  output logic lead_o,
  output logic trail_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_s;
  logic                   fall_s;

  // Synchroniser chain and one-cycle history of the synchronised level
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
      prev_q <= RST_LVL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_s  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_s  = ~sync_q[SYNC_STAGES-1] & prev_q;
  assign lead_o  = LEAD_FALL ? fall_s : rise_s;
  assign trail_o = LEAD_FALL ? rise_s : fall_s;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI responder: oversampled SCLK/CS/MOSI, word-wide RX shift and staged TX word on MISO.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int   SPI_MODE    = 0,
  parameter int   NO_OF_BYTES = 1,
  parameter logic IDLE_MISO   = 1'b1
) (
  input logic                  i_Clk,
  input logic                  i_Rst_L,
  spi_slave_responder_if.slave bus
);

  localparam logic CPOL  = cpol(SPI_MODE);
  localparam logic CPHA  = cpha(SPI_MODE);
  localparam int   W     = 8 * NO_OF_BYTES;
  localparam int   CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  state_e                 state_q;
  logic [W-1:0]           stage_q;
  logic                   stage_full_q;
  logic [W-1:0]           tx_shift_q;
  logic [W-1:0]           rx_shift_q;
  logic [W-1:0]           rx_byte_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   rx_dv_q;
  logic                   rx_abort_q;
  logic                   miso_q;
  logic                   miso_en_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  logic sclk_lead_s, sclk_trail_s, cs_fall_s, cs_rise_s;
  logic sample_s, shift_s;
  logic [W-1:0] load_word_d;
  logic [W-1:0] rx_word_d;

  spi_edge_sync #(.RST_LVL(CPOL), .LEAD_FALL(CPOL)) u_sclk_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .pin_i   (bus.i_SPI_Clk),
    .lead_o  (sclk_lead_s),
    .trail_o (sclk_trail_s)
  );

  // CS resets to the asserted level so a frame cut by reset cannot restart until CS is re-dropped
  spi_edge_sync #(.RST_LVL(1'b0), .LEAD_FALL(1'b1)) u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .pin_i   (bus.i_SPI_CS_n),
    .lead_o  (cs_fall_s),
    .trail_o (cs_rise_s)
  );

  assign sample_s    = CPHA ? sclk_trail_s : sclk_lead_s;
  assign shift_s     = CPHA ? sclk_lead_s  : sclk_trail_s;
  assign load_word_d = stage_full_q ? stage_q : {W{1'b1}};
  assign rx_word_d   = {rx_shift_q[W-2:0], mosi_q[SYNC_STAGES-1]};

  // MOSI synchroniser, same depth as the SCLK path so samples line up with the tick
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
    end
  end

  // Frame FSM with registered outputs; the host write comes last so it wins over a same-cycle load
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      bit_cnt_q    <= '0;
      rx_dv_q      <= 1'b0;
      rx_abort_q   <= 1'b0;
      miso_q       <= IDLE_MISO;
      miso_en_q    <= 1'b0;
    end else begin
      rx_dv_q    <= 1'b0;
      rx_abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall_s) begin
            state_q      <= ACTIVE;
            bit_cnt_q    <= '0;
            miso_en_q    <= 1'b1;
            stage_full_q <= 1'b0;
            if (CPHA) begin
              tx_shift_q <= load_word_d;
            end else begin
              // MSb goes out now; the shift register keeps only what the shift ticks still owe
              miso_q     <= load_word_d[W-1];
              tx_shift_q <= {load_word_d[W-2:0], 1'b0};
            end
          end
        end
        ACTIVE: begin
          if (cs_rise_s) begin
            state_q    <= IDLE;
            miso_en_q  <= 1'b0;
            miso_q     <= IDLE_MISO;
            rx_abort_q <= (bit_cnt_q != '0);
          end else if (sample_s) begin
            rx_shift_q <= rx_word_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q    <= '0;
              rx_byte_q    <= rx_word_d;
              rx_dv_q      <= 1'b1;
              tx_shift_q   <= load_word_d;
              stage_full_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else if (shift_s) begin
            miso_q     <= tx_shift_q[W-1];
            tx_shift_q <= {tx_shift_q[W-2:0], 1'b0};
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (bus.i_TX_DV) begin
        stage_q      <= bus.i_TX_Byte;
        stage_full_q <= 1'b1;
      end
    end
  end

  assign bus.o_TX_Ready    = ~stage_full_q;
  assign bus.o_RX_DV       = rx_dv_q;
  assign bus.o_RX_Byte     = rx_byte_q;
  assign bus.o_RX_Abort    = rx_abort_q;
  assign bus.o_SPI_MISO    = miso_q;
  assign bus.o_SPI_MISO_En = miso_en_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench: four 1-byte responders (modes 0-3) plus one 2-byte mode-0 responder, driven by a bit-banged master.
module tb_spi_slave_responder;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]       sclk, csn, mosi, txdv;
  logic [4:0][15:0] tx_byte, rx_byte;
  logic [4:0]       miso, miso_en, rdy, rx_dv, rx_ab;

  int dv_cnt[5] = '{default: 0};
  int ab_cnt[5] = '{default: 0};
  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int NB   = (g == 4) ? 2 : 1;
    localparam int MODE = (g == 4) ? 0 : g;
    spi_slave_responder_if #(.NO_OF_BYTES(NB)) bus ();
    assign bus.i_TX_Byte  = tx_byte[g][8*NB-1:0];
    assign bus.i_TX_DV    = txdv[g];
    assign bus.i_SPI_Clk  = sclk[g];
    assign bus.i_SPI_CS_n = csn[g];
    assign bus.i_SPI_MOSI = mosi[g];
    assign rx_byte[g]     = 16'(bus.o_RX_Byte);
    assign rdy[g]         = bus.o_TX_Ready;
    assign rx_dv[g]       = bus.o_RX_DV;
    assign rx_ab[g]       = bus.o_RX_Abort;
    assign miso[g]        = bus.o_SPI_MISO;
    assign miso_en[g]     = bus.o_SPI_MISO_En;
    spi_slave_responder #(.SPI_MODE(MODE), .NO_OF_BYTES(NB), .IDLE_MISO(1'b1)) dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_n),
      .bus     (bus)
    );
  end

  // Pulse-width aware counters: a pulse longer than one cycle counts more than once
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rx_dv[i]) dv_cnt[i]++;
      if (rx_ab[i]) ab_cnt[i]++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic stage(input int d, input logic [15:0] w);
    tx_byte[d] = w;
    txdv[d]    = 1'b1;
    wait_cyc(1);
    txdv[d]    = 1'b0;
  endtask

  task automatic cs_low(input int d);
    csn[d] = 1'b0;
    wait_cyc(H);
  endtask

  task automatic cs_high(input int d);
    wait_cyc(H);
    csn[d] = 1'b1;
    wait_cyc(H);
  endtask

  // Master side: drives MOSI, samples MISO at the sample edge and checks MISO holds past it
  task automatic xfer(input int d, input int n, input logic [15:0] tx,
                      output logic [15:0] rx, output int unstable);
    int   m;
    logic pol, pha;
    m   = (d == 4) ? 0 : d;
    pol = (m >= 2);
    pha = (m == 1) || (m == 3);
    rx = '0;
    unstable = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!pha) begin
        mosi[d] = tx[i];
        wait_cyc(H);
        rx[i]   = miso[d];
        sclk[d] = ~pol;
      end else begin
        sclk[d] = ~pol;
        mosi[d] = tx[i];
        wait_cyc(H);
        rx[i]   = miso[d];
        sclk[d] = pol;
      end
      wait_cyc(5);
      if (miso[d] !== rx[i]) unstable++;
      wait_cyc(H - 5);
      if (!pha) sclk[d] = pol;
    end
  endtask

  typedef struct {
    int          d;
    logic        stg;
    logic [15:0] txw;
    logic [15:0] mosiw;
    int          nbits;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
  } vec_t;

  initial begin
    vec_t        vt[7];
    logic [15:0] got;
    int          unst, dv0, ab0, d;

    vt[0] = '{0, 1'b1, 16'h00A5, 16'h003C,  8, 16'h003C, 16'h00A5};
    vt[1] = '{1, 1'b1, 16'h0081, 16'h007E,  8, 16'h007E, 16'h0081};
    vt[2] = '{2, 1'b1, 16'h0081, 16'h007E,  8, 16'h007E, 16'h0081};
    vt[3] = '{3, 1'b1, 16'h0081, 16'h007E,  8, 16'h007E, 16'h0081};
    vt[4] = '{0, 1'b0, 16'h0000, 16'h0055,  8, 16'h0055, 16'h00FF};
    vt[5] = '{4, 1'b1, 16'hC3A5, 16'h0F0F, 16, 16'h0F0F, 16'hC3A5};
    vt[6] = '{3, 1'b0, 16'h0000, 16'h0000,  8, 16'h0000, 16'h00FF};

    rst_n   = 1'b0;
    sclk    = 5'b01100;
    csn     = 5'b11111;
    mosi    = 5'b00000;
    txdv    = 5'b00000;
    tx_byte = '0;
    wait_cyc(5);
    chk("rst_tx_ready", rdy, 32'h1F);
    chk("rst_miso_en", miso_en, 32'h0);
    chk("rst_miso", miso, 32'h1F);
    chk("rst_rx_dv", rx_dv, 32'h0);
    chk("rst_rx_abort", rx_ab, 32'h0);
    chk("rst_rx_byte0", rx_byte[0], 32'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    for (int k = 0; k < 7; k++) begin
      d   = vt[k].d;
      dv0 = dv_cnt[d];
      ab0 = ab_cnt[d];
      if (vt[k].stg) stage(d, vt[k].txw);
      cs_low(d);
      chk($sformatf("v%0d_miso_en_active", k), miso_en[d], 32'h1);
      xfer(d, vt[k].nbits, vt[k].mosiw, got, unst);
      cs_high(d);
      chk($sformatf("v%0d_rx_byte", k), rx_byte[d], vt[k].exp_rx);
      chk($sformatf("v%0d_miso_word", k), got, vt[k].exp_miso);
      chk($sformatf("v%0d_rx_dv_count", k), dv_cnt[d] - dv0, 32'd1);
      chk($sformatf("v%0d_abort_count", k), ab_cnt[d] - ab0, 32'd0);
      chk($sformatf("v%0d_miso_stable", k), unst, 32'd0);
      chk($sformatf("v%0d_miso_en_idle", k), miso_en[d], 32'h0);
      chk($sformatf("v%0d_miso_idle", k), miso[d], 32'h1);
      chk($sformatf("v%0d_tx_ready", k), rdy[d], 32'h1);
    end

    // Two back-to-back 16-bit words in one frame, second word staged during the first
    dv0 = dv_cnt[4];
    stage(4, 16'hBEEF);
    chk("w2_ready_staged", rdy[4], 32'h0);
    cs_low(4);
    chk("w2_ready_after_load", rdy[4], 32'h1);
    stage(4, 16'h1234);
    chk("w2_ready_restaged", rdy[4], 32'h0);
    xfer(4, 16, 16'hA1B2, got, unst);
    chk("w2_word1_miso", got, 32'hBEEF);
    chk("w2_word1_rx", rx_byte[4], 32'hA1B2);
    chk("w2_word1_dv", dv_cnt[4] - dv0, 32'd1);
    chk("w2_ready_reloaded", rdy[4], 32'h1);
    xfer(4, 16, 16'hC3D4, got, unst);
    cs_high(4);
    chk("w2_word2_miso", got, 32'h1234);
    chk("w2_word2_rx", rx_byte[4], 32'hC3D4);
    chk("w2_dv_total", dv_cnt[4] - dv0, 32'd2);

    // Abort after 5 bits, then last-write-wins staging on the recovery frame
    dv0 = dv_cnt[0];
    ab0 = ab_cnt[0];
    cs_low(0);
    xfer(0, 5, 16'h0015, got, unst);
    cs_high(0);
    chk("ab_abort_pulse", ab_cnt[0] - ab0, 32'd1);
    chk("ab_no_dv", dv_cnt[0] - dv0, 32'd0);
    chk("ab_rx_kept", rx_byte[0], 32'h0055);
    stage(0, 16'h0033);
    stage(0, 16'h0066);
    chk("ab_ready_full", rdy[0], 32'h0);
    cs_low(0);
    xfer(0, 8, 16'h0096, got, unst);
    cs_high(0);
    chk("ab_next_rx", rx_byte[0], 32'h0096);
    chk("ab_next_miso", got, 32'h0066);
    chk("ab_next_dv", dv_cnt[0] - dv0, 32'd1);

    // Asynchronous reset three bits into a mode-1 frame
    cs_low(1);
    stage(1, 16'h0077);
    xfer(1, 3, 16'h0005, got, unst);
    dv0 = dv_cnt[1];
    rst_n = 1'b0;
    #1;
    chk("mr_miso_en", miso_en[1], 32'h0);
    chk("mr_miso", miso[1], 32'h1);
    chk("mr_tx_ready", rdy[1], 32'h1);
    chk("mr_rx_byte", rx_byte[1], 32'h0);
    chk("mr_rx_abort", rx_ab[1], 32'h0);
    wait_cyc(4);
    csn[1] = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(2 * H);
    chk("mr_quiet_dv", dv_cnt[1] - dv0, 32'd0);
    chk("mr_quiet_en", miso_en[1], 32'h0);
    stage(1, 16'h0042);
    cs_low(1);
    xfer(1, 8, 16'h0099, got, unst);
    cs_high(1);
    chk("mr_next_rx", rx_byte[1], 32'h0099);
    chk("mr_next_miso", got, 32'h0042);
    chk("mr_next_dv", dv_cnt[1] - dv0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI responder (slave) for the verification environment: answers transfers from the SPI master and the DUT's SPI ports.
- Oversamples the incoming SPI clock, chip-select and MOSI on the local clock.
- Shifts received MOSI bits into a word and returns a staged word on MISO.
- Supports SPI modes 0-3 and multi-byte words, so frames from the master can be checked bit-exactly in both directions.

Parameters:
- SPI_MODE, 0, SPI mode 0-3. CPOL = (mode 2 or 3); CPHA = (mode 1 or 3).
- NO_OF_BYTES, 1, word length = 8*NO_OF_BYTES bits, MSb first.
- IDLE_MISO, 1'b1, level driven on o_SPI_MISO while o_SPI_MISO_En is low.

Ports:
- i_Clk  input  1  local clock; must run at >= 8x the SPI clock.
- i_Rst_L  input  1  reset, asynchronous, active-low.
- i_TX_Byte  input  8*NO_OF_BYTES  word to return on MISO in the next frame.
- i_TX_DV  input  1  1-cycle pulse; writes i_TX_Byte to the staging register.
- o_TX_Ready  output  1  staging register empty, can accept i_TX_DV.
- o_RX_DV  output  1  1-cycle pulse; o_RX_Byte holds a complete word.
- o_RX_Byte  output  8*NO_OF_BYTES  last complete received word.
- o_RX_Abort  output  1  1-cycle pulse; CS deasserted mid-word.
- i_SPI_Clk  input  1  SPI clock from the master.
- i_SPI_CS_n  input  1  chip select, active-low.
- i_SPI_MOSI  input  1  serial data from the master.
- o_SPI_MISO  output  1  serial data to the master.
- o_SPI_MISO_En  output  1  MISO drive enable; high only while CS is low.

Behaviour:
- Reset values: o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0, o_RX_Abort=0, o_SPI_MISO=IDLE_MISO, o_SPI_MISO_En=0. TX shift, RX shift, staging register and bit counter all 0. State IDLE.
- Input synchronisation: 2-flop synchronisers on SCLK, CS_n and MOSI.
- Edge detection: compare the synchronised SCLK with its previous sample.
  - Leading edge = rising when CPOL=0, falling when CPOL=1. Trailing edge = the opposite.
  - Sample tick = leading edge if CPHA=0, trailing edge if CPHA=1. Shift tick = the other edge.
  - Latency is 3 i_Clk cycles from a pin edge to its tick.
- State IDLE -> ACTIVE on the synchronised CS falling edge, at which the block:
  - loads the TX shift register from the staging register if it is full (staging becomes empty, o_TX_Ready rises next cycle); otherwise loads all-ones;
  - clears the bit counter and asserts o_SPI_MISO_En;
  - drives the MSb on MISO immediately if CPHA=0.
- ACTIVE, sample tick: shift the synchronised MOSI into the RX shift register LSb side; increment the counter.
- ACTIVE, shift tick:
  - CPHA=1: drive the next TX bit on every shift tick, the MSb first.
  - CPHA=0: the MSb was driven at CS fall; drive the next bit on every shift tick except the one closing a word.
- Word complete: on the sample tick where the count reaches 8*NO_OF_BYTES-1:
  - o_RX_Byte is updated with the full word and o_RX_DV pulses on the next cycle;
  - the counter wraps to 0;
  - the TX shift register reloads (staging or all-ones), so back-to-back words within one CS frame are supported.
- State ACTIVE -> IDLE on the synchronised CS rising edge:
  - o_SPI_MISO_En drops and MISO returns to IDLE_MISO;
  - if the counter is non-zero, o_RX_Abort pulses 1 cycle, the partial word is discarded and o_RX_Byte is unchanged;
  - the staging register is untouched.
- Ticks while IDLE are ignored.
- i_TX_DV while o_TX_Ready=0: the new word overwrites the staging register (last write wins).
- i_TX_DV in the same cycle as a TX load: the old staged value loads; the new value remains staged and o_TX_Ready stays 0.
- Asynchronous reset mid-frame: immediate return to reset values. After reset the block resumes only on a fresh CS falling edge.

Decomposition:
- Shared package spi_pkg holds:
  - mode decode functions cpol(mode) and cpha(mode);
  - the localparam SYNC_STAGES=2;
  - the state enum {IDLE, ACTIVE}.
- The master side uses the same CPOL/CPHA decode.
- One natural sub-module: spi_edge_sync, a 2-flop synchroniser plus edge detector emitting lead/trail pulses. Instantiated for SCLK; CS uses the same structure.

Test Plan:
- Mode 0, NO_OF_BYTES=1, staged 8'hA5, master sends 8'h3C -> o_RX_DV once with o_RX_Byte=8'h3C; master receives 8'hA5.
- Modes 1, 2 and 3 each, staged 8'h81, master sends 8'h7E -> exchange correct in each mode; MISO changes only on the shift edge for that mode.
- NO_OF_BYTES=2, one CS frame of 2 words, staged 16'hBEEF then 16'h1234 loaded during word 1 -> RX DV twice, master receives BEEF then 1234.
- Nothing staged, master sends 8'h55 -> master receives 8'hFF; o_RX_Byte=8'h55.
- CS raised after 5 bits -> o_RX_Abort pulses 1 cycle, no o_RX_DV, o_RX_Byte retains the prior value, next full frame is received correctly.
- i_Rst_L low after 3 bits -> all outputs take reset values immediately; the next frame after release completes normally.
